// File: rtl/bcd_entry_buffer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_entry_buffer_pkg
// Shared definitions for the keypad entry buffer: display slot codes, the
// entry state type and a helper that sizes counters.
// No ports (package).
// ---------------------------------------------------------------------------
package bcd_entry_buffer_pkg;

    localparam logic [3:0] BLANK      = 4'hF;
    localparam logic [3:0] DP_CODE    = 4'hE;
    localparam logic [3:0] MINUS_CODE = 4'hD;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        INT   = 2'd1,
        FRAC  = 2'd2,
        HOLD  = 2'd3
    } entry_state_t;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_entry_buffer_if.sv
// ---------------------------------------------------------------------------
// bcd_entry_buffer_if
// Keypad strobes, display bus and ALU operand handshake for the entry buffer.
//   master : keypad decoder / ALU side (drives strobes, digit, out_ready)
//   slave  : entry buffer (drives bcdreg, operand, out_valid, pulses)
// Optional sign entry (neg / out_neg) exists only when SIGN_ENTRY_EN is
// defined.
// ---------------------------------------------------------------------------
interface bcd_entry_buffer_if #(
    parameter int NUM_DIGITS = 8,
    parameter int MAX_FRAC   = 2
) ();

    localparam int FW = bcd_entry_buffer_pkg::cnt_w(MAX_FRAC);

    logic [3:0]              digit;
    logic                    load;
    logic                    dp;
    logic                    bksp;
    logic                    clear;
    logic                    commit;
`ifdef SIGN_ENTRY_EN
    logic                    neg;
    logic                    out_neg;
`endif
    logic [4*NUM_DIGITS-1:0] bcdreg;
    logic [4*NUM_DIGITS-1:0] out_value;
    logic [FW-1:0]           out_frac;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overflow;
    logic                    bad_digit;

    modport master (
        output digit, load, dp, bksp, clear, commit, out_ready,
`ifdef SIGN_ENTRY_EN
        output neg,
        input  out_neg,
`endif
        input  bcdreg, out_value, out_frac, out_valid, overflow, bad_digit
    );

    modport slave (
        input  digit, load, dp, bksp, clear, commit, out_ready,
`ifdef SIGN_ENTRY_EN
        input  neg,
        output out_neg,
`endif
        output bcdreg, out_value, out_frac, out_valid, overflow, bad_digit
    );

endinterface

// File: rtl/bcd_entry_buffer_pack.sv
// ---------------------------------------------------------------------------
// bcd_pack
// Combinational operand packer. Drops every non-digit slot (DP, blank,
// minus) and right-justifies the remaining digits, zero-filling the top.
//   slots        in   4*NUM_DIGITS  display slots, slot 0 rightmost
//   packed_value out  4*NUM_DIGITS  packed BCD digits, no DP
// ---------------------------------------------------------------------------
module bcd_pack #(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] slots,
    output logic [4*NUM_DIGITS-1:0] packed_value
);

    always_comb begin
        int unsigned pos;
        packed_value = '0;
        pos          = 0;
        // pos never exceeds i, so the write index always stays in range.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slots[4*i +: 4] <= 4'd9) begin
                packed_value[4*pos +: 4] = slots[4*i +: 4];
                pos = pos + 1;
            end
        end
    end

endmodule

// File: rtl/bcd_entry_buffer.sv
// ---------------------------------------------------------------------------
// bcd_entry_buffer
// Keypad numeric entry buffer: accumulates right-justified BCD digits with
// decimal point, backspace, clear and capacity limits, drives the display,
// and hands a DP-free operand to the ALU over a valid/ready handshake.
//   clock  in   rising-edge clock
//   reset  in   asynchronous, active-high
//   bus    slave modport of bcd_entry_buffer_if (strobes, display, operand)
// Optional feature: define SIGN_ENTRY_EN to add neg / out_neg sign entry.
// ---------------------------------------------------------------------------
module bcd_entry_buffer
    import bcd_entry_buffer_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int MAX_FRAC   = 2
) (
    input  logic              clock,
    input  logic              reset,
    bcd_entry_buffer_if.slave bus
);

    localparam int              SW        = cnt_w(NUM_DIGITS);
    localparam int              FW        = cnt_w(MAX_FRAC);
    localparam int              BW        = 4 * NUM_DIGITS;
    localparam logic [SW-1:0]   N_SW      = SW'(NUM_DIGITS);
    localparam logic [SW-1:0]   ONE_S     = SW'(1);
    localparam logic [SW-1:0]   TWO_S     = SW'(2);
    localparam logic [FW-1:0]   MAXF      = FW'(MAX_FRAC);
    localparam logic [FW-1:0]   ONE_F     = FW'(1);
    localparam logic [BW-1:0]   ALL_BLANK = {NUM_DIGITS{BLANK}};

    // body holds digits and DP only; the minus sign is overlaid on output.
    entry_state_t  state_reg,  state_next;
    logic [BW-1:0] body_reg,   body_next;
    logic [SW-1:0] nslots_reg, nslots_next;
    logic [FW-1:0] frac_reg,   frac_next;
    logic [BW-1:0] value_reg,  value_next;
    logic [FW-1:0] ofrac_reg,  ofrac_next;
    logic          valid_reg,  valid_next;
    logic          ovf_reg,    ovf_next;
    logic          bad_reg,    bad_next;
`ifdef SIGN_ENTRY_EN
    logic          neg_reg,    neg_next;
    logic          oneg_reg,   oneg_next;
`endif

    logic          sign_on;
    logic [SW-1:0] cap;
    logic [BW-1:0] pack_value;
    logic          to_empty;

`ifdef SIGN_ENTRY_EN
    assign sign_on = neg_reg;
`else
    assign sign_on = 1'b0;
`endif

    // A shown minus occupies one display slot.
    assign cap = N_SW - SW'(sign_on);

    bcd_pack #(.NUM_DIGITS(NUM_DIGITS)) u_pack (
        .slots        (body_reg),
        .packed_value (pack_value)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= EMPTY;
            body_reg   <= ALL_BLANK;
            nslots_reg <= '0;
            frac_reg   <= '0;
            value_reg  <= '0;
            ofrac_reg  <= '0;
            valid_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            bad_reg    <= 1'b0;
`ifdef SIGN_ENTRY_EN
            neg_reg    <= 1'b0;
            oneg_reg   <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            body_reg   <= body_next;
            nslots_reg <= nslots_next;
            frac_reg   <= frac_next;
            value_reg  <= value_next;
            ofrac_reg  <= ofrac_next;
            valid_reg  <= valid_next;
            ovf_reg    <= ovf_next;
            bad_reg    <= bad_next;
`ifdef SIGN_ENTRY_EN
            neg_reg    <= neg_next;
            oneg_reg   <= oneg_next;
`endif
        end
    end

    // Next-state logic: clear > (HOLD handshake) > bksp > dp > neg > load > commit
    always_comb begin
        state_next  = state_reg;
        body_next   = body_reg;
        nslots_next = nslots_reg;
        frac_next   = frac_reg;
        value_next  = value_reg;
        ofrac_next  = ofrac_reg;
        valid_next  = valid_reg;
        ovf_next    = 1'b0;
        bad_next    = 1'b0;
        to_empty    = 1'b0;
`ifdef SIGN_ENTRY_EN
        neg_next    = neg_reg;
        oneg_next   = oneg_reg;
`endif
        if (bus.clear) begin
            to_empty   = 1'b1;
            valid_next = 1'b0;
        end else if (state_reg == HOLD) begin
            if (valid_reg && bus.out_ready) begin
                to_empty   = 1'b1;
                valid_next = 1'b0;
            end
        end else if (bus.bksp) begin
            if (state_reg != EMPTY) begin
                body_next   = {BLANK, body_reg[BW-1:4]};
                nslots_next = nslots_reg - ONE_S;
                if (body_reg[3:0] == DP_CODE) begin
                    state_next = INT;
                end else if (state_reg == FRAC) begin
                    frac_next = frac_reg - ONE_F;
                end
                if (nslots_reg == ONE_S) begin
                    to_empty = 1'b1;
                end
            end
        end else if (bus.dp) begin
            if (state_reg == EMPTY) begin
                body_next   = {{(NUM_DIGITS-2){BLANK}}, 4'h0, DP_CODE};
                nslots_next = TWO_S;
                frac_next   = '0;
                state_next  = FRAC;
            end else if (state_reg == INT) begin
                // Leave room for at least one fractional digit after the DP.
                if (nslots_reg <= cap - TWO_S) begin
                    body_next   = {body_reg[BW-5:0], DP_CODE};
                    nslots_next = nslots_reg + ONE_S;
                    frac_next   = '0;
                    state_next  = FRAC;
                end else begin
                    ovf_next = 1'b1;
                end
            end
        end
`ifdef SIGN_ENTRY_EN
        else if (bus.neg) begin
            if (state_reg != EMPTY) begin
                if (neg_reg) begin
                    neg_next = 1'b0;
                end else if (nslots_reg < N_SW) begin
                    neg_next = 1'b1;
                end else begin
                    ovf_next = 1'b1;
                end
            end
        end
`endif
        else if (bus.load) begin
            if (bus.digit > 4'd9) begin
                bad_next = 1'b1;
            end else if (state_reg == EMPTY) begin
                body_next   = {ALL_BLANK[BW-1:4], bus.digit};
                nslots_next = ONE_S;
                state_next  = INT;
            end else if (state_reg == INT) begin
                if (nslots_reg == ONE_S && body_reg[3:0] == 4'h0) begin
                    body_next[3:0] = bus.digit;  // no leading zeros
                end else if (nslots_reg < cap) begin
                    body_next   = {body_reg[BW-5:0], bus.digit};
                    nslots_next = nslots_reg + ONE_S;
                end else begin
                    ovf_next = 1'b1;
                end
            end else begin
                if (frac_reg < MAXF && nslots_reg < cap) begin
                    body_next   = {body_reg[BW-5:0], bus.digit};
                    nslots_next = nslots_reg + ONE_S;
                    frac_next   = frac_reg + ONE_F;
                end else begin
                    ovf_next = 1'b1;
                end
            end
        end else if (bus.commit) begin
            value_next = pack_value;
            ofrac_next = frac_reg;
            valid_next = 1'b1;
            state_next = HOLD;
`ifdef SIGN_ENTRY_EN
            oneg_next  = neg_reg;
`endif
        end

        if (to_empty) begin
            body_next   = ALL_BLANK;
            nslots_next = '0;
            frac_next   = '0;
            state_next  = EMPTY;
`ifdef SIGN_ENTRY_EN
            neg_next    = 1'b0;
`endif
        end
    end

    // Output logic: display with the minus overlaid left of the leftmost slot.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        assign bus.bcdreg[4*gi +: 4] = (sign_on && nslots_reg == SW'(gi)) ? MINUS_CODE
                                                                           : body_reg[4*gi +: 4];
    end

    assign bus.out_value = value_reg;
    assign bus.out_frac  = ofrac_reg;
    assign bus.out_valid = valid_reg;
    assign bus.overflow  = ovf_reg;
    assign bus.bad_digit = bad_reg;
`ifdef SIGN_ENTRY_EN
    assign bus.out_neg   = oneg_reg;
`endif

endmodule

// File: tb/tb_bcd_entry_buffer.sv
// ---------------------------------------------------------------------------
// tb_bcd_entry_buffer
// Self-checking bench for bcd_entry_buffer (NUM_DIGITS=8, MAX_FRAC=2).
// Directed vector table, hand-written hold/async-reset sequences, and a
// randomized run compared against a digit-queue model of the entry rules.
// ---------------------------------------------------------------------------
module tb_bcd_entry_buffer;

    localparam int N    = 8;
    localparam int MAXF = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bcd_entry_buffer_if #(.NUM_DIGITS(N), .MAX_FRAC(MAXF)) bus ();

    bcd_entry_buffer #(.NUM_DIGITS(N), .MAX_FRAC(MAXF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // ---------------- reference model: integer/fraction digit lists -------
    int          int_q[$];
    int          frac_q[$];
    bit          has_dp, hold, m_valid, m_ovf, m_bad;
    logic [31:0] m_value;
    int          m_frac;

    task automatic model_empty();
        int_q.delete();
        frac_q.delete();
        has_dp = 1'b0;
        hold   = 1'b0;
    endtask

    task automatic model_reset();
        model_empty();
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_bad   = 1'b0;
        m_value = '0;
        m_frac  = 0;
    endtask

    function automatic logic [31:0] model_disp();
        logic [31:0] d;
        d = 32'hFFFF_FFFF;
        foreach (int_q[i]) d = (d << 4) | 32'(int_q[i]);
        if (has_dp) d = (d << 4) | 32'hE;
        foreach (frac_q[i]) d = (d << 4) | 32'(frac_q[i]);
        return d;
    endfunction

    function automatic logic [31:0] model_number();
        logic [31:0] v;
        v = '0;
        foreach (int_q[i]) v = (v << 4) | 32'(int_q[i]);
        foreach (frac_q[i]) v = (v << 4) | 32'(frac_q[i]);
        return v;
    endfunction

    task automatic model_apply(input bit ld, dpp, bk, cl, cm, rdy, input int dig);
        int slots;
        slots = int_q.size() + int'(has_dp) + frac_q.size();
        m_ovf = 1'b0;
        m_bad = 1'b0;
        if (cl) begin
            model_empty();
            m_valid = 1'b0;
        end else if (hold) begin
            if (rdy) begin
                model_empty();
                m_valid = 1'b0;
            end
        end else if (bk) begin
            if (frac_q.size() > 0) void'(frac_q.pop_back());
            else if (has_dp) has_dp = 1'b0;
            else if (int_q.size() > 0) void'(int_q.pop_back());
        end else if (dpp) begin
            if (slots == 0) begin
                int_q.push_back(0);
                has_dp = 1'b1;
            end else if (!has_dp) begin
                if (slots <= N - 2) has_dp = 1'b1;
                else m_ovf = 1'b1;
            end
        end else if (ld) begin
            if (dig > 9) m_bad = 1'b1;
            else if (slots == 0) int_q.push_back(dig);
            else if (!has_dp) begin
                if (int_q.size() == 1 && int_q[0] == 0) int_q[0] = dig;
                else if (slots < N) int_q.push_back(dig);
                else m_ovf = 1'b1;
            end else begin
                if (frac_q.size() < MAXF && slots < N) frac_q.push_back(dig);
                else m_ovf = 1'b1;
            end
        end else if (cm) begin
            m_value = model_number();
            m_frac  = frac_q.size();
            m_valid = 1'b1;
            hold    = 1'b1;
        end
    endtask

    // ---------------- checking helpers -----------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit ld, dpp, bk, cl, cm, rdy, input logic [3:0] dig);
        bus.load      = ld;
        bus.dp        = dpp;
        bus.bksp      = bk;
        bus.clear     = cl;
        bus.commit    = cm;
        bus.out_ready = rdy;
        bus.digit     = dig;
        @(posedge clock);
        #1;
        bus.load = 1'b0; bus.dp = 1'b0; bus.bksp = 1'b0;
        bus.clear = 1'b0; bus.commit = 1'b0; bus.out_ready = 1'b0;
        step_no++;
        model_apply(ld, dpp, bk, cl, cm, rdy, int'(dig));
        $display("step %0d ld=%0b dp=%0b bk=%0b cl=%0b cm=%0b rdy=%0b dig=%0d -> bcd=%h ovf=%0b bad=%0b vld=%0b val=%h frac=%0d",
                 step_no, ld, dpp, bk, cl, cm, rdy, dig, bus.bcdreg, bus.overflow,
                 bus.bad_digit, bus.out_valid, bus.out_value, bus.out_frac);
        check($sformatf("model bcdreg @%0d", step_no),    bus.bcdreg,             model_disp());
        check($sformatf("model overflow @%0d", step_no),  32'(bus.overflow),      32'(m_ovf));
        check($sformatf("model bad_digit @%0d", step_no), 32'(bus.bad_digit),     32'(m_bad));
        check($sformatf("model out_valid @%0d", step_no), 32'(bus.out_valid),     32'(m_valid));
        check($sformatf("model out_value @%0d", step_no), bus.out_value,          m_value);
        check($sformatf("model out_frac @%0d", step_no),  32'(bus.out_frac),      32'(m_frac));
    endtask

    // ---------------- directed vector table ------------------------------
    typedef struct {
        bit          ld, dpp, bk, cl, cm, rdy;
        logic [3:0]  dig;
        logic [31:0] e_bcd;
        bit          e_ovf, e_bad, e_vld;
        logic [31:0] e_val;
        int          e_frac;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit ld, dpp, bk, cl, cm, rdy, input logic [3:0] dig,
                                input logic [31:0] e_bcd, input bit e_ovf, e_bad, e_vld,
                                input logic [31:0] e_val, input int e_frac);
        vec_t v;
        v.ld = ld; v.dpp = dpp; v.bk = bk; v.cl = cl; v.cm = cm; v.rdy = rdy; v.dig = dig;
        v.e_bcd = e_bcd; v.e_ovf = e_ovf; v.e_bad = e_bad; v.e_vld = e_vld;
        v.e_val = e_val; v.e_frac = e_frac;
        return v;
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ld, dpp, bk, cl, cm, rdy;
        logic [3:0] dig;

        bus.digit = '0; bus.load = 1'b0; bus.dp = 1'b0; bus.bksp = 1'b0;
        bus.clear = 1'b0; bus.commit = 1'b0; bus.out_ready = 1'b0;
`ifdef SIGN_ENTRY_EN
        bus.neg = 1'b0;
`endif
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset bcdreg",    bus.bcdreg,            32'hFFFF_FFFF);
        check("reset out_value", bus.out_value,         32'h0);
        check("reset out_frac",  32'(bus.out_frac),     32'h0);
        check("reset out_valid", 32'(bus.out_valid),    32'h0);
        check("reset overflow",  32'(bus.overflow),     32'h0);
        check("reset bad_digit", 32'(bus.bad_digit),    32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        //                  ld dp bk cl cm rd dig   bcdreg        ov bd vl value         frac
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd1, 32'hFFFFFFF1, 0, 0, 0, 32'h00000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd2, 32'hFFFFFF12, 0, 0, 0, 32'h00000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd3, 32'hFFFFF123, 0, 0, 0, 32'h00000000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4'd0, 32'hFFFFF123, 0, 0, 1, 32'h00000123, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4'd0, 32'hFFFFFFFF, 0, 0, 0, 32'h00000123, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd0, 32'hFFFFFFF0, 0, 0, 0, 32'h00000123, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd0, 32'hFFFFFFF0, 0, 0, 0, 32'h00000123, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd7, 32'hFFFFFFF7, 0, 0, 0, 32'h00000123, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4'd0, 32'hFFFFFF7E, 0, 0, 0, 32'h00000123, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd5, 32'hFFFFF7E5, 0, 0, 0, 32'h00000123, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd5, 32'hFFFF7E55, 0, 0, 0, 32'h00000123, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd5, 32'hFFFF7E55, 1, 0, 0, 32'h00000123, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4'd0, 32'hFFFF7E55, 0, 0, 1, 32'h00000755, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4'd0, 32'hFFFFFFFF, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'hFFFFFFF9, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'hFFFFFF99, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'hFFFFF999, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'hFFFF9999, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'hFFF99999, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'hFF999999, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'hF9999999, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'h99999999, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9, 32'h99999999, 1, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4'd0, 32'h99999999, 1, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 4'd3, 32'hFFFFFFFF, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4'd0, 32'hFFFFFF0E, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'd0, 32'hFFFFFFF0, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'd0, 32'hFFFFFFFF, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'd0, 32'hFFFFFFFF, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd4, 32'hFFFFFFF4, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 4'd5, 32'hFFFFFFFF, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'hA, 32'hFFFFFFFF, 0, 1, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd1, 32'hFFFFFFF1, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'd2, 32'hFFFFFF12, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4'd0, 32'hFFFFF12E, 0, 0, 0, 32'h00000755, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4'd0, 32'hFFFFF12E, 0, 0, 1, 32'h00000012, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4'd0, 32'hFFFFFFFF, 0, 0, 0, 32'h00000012, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4'd0, 32'hFFFFFFFF, 0, 0, 1, 32'h00000000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4'd0, 32'hFFFFFFFF, 0, 0, 0, 32'h00000000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].dpp, vecs[i].bk, vecs[i].cl, vecs[i].cm, vecs[i].rdy, vecs[i].dig);
            check($sformatf("vec%0d bcdreg", i),    bus.bcdreg,         vecs[i].e_bcd);
            check($sformatf("vec%0d overflow", i),  32'(bus.overflow),  32'(vecs[i].e_ovf));
            check($sformatf("vec%0d bad_digit", i), 32'(bus.bad_digit), 32'(vecs[i].e_bad));
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_vld));
            check($sformatf("vec%0d out_value", i), bus.out_value,      vecs[i].e_val);
            check($sformatf("vec%0d out_frac", i),  32'(bus.out_frac),  32'(vecs[i].e_frac));
        end

        // Hold with out_ready low: operand held, loads ignored, clear abandons it.
        step(1, 0, 0, 0, 0, 0, 4'd8);
        step(0, 0, 0, 0, 1, 0, 4'd0);
        check("hold out_value", bus.out_value, 32'h00000008);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0, 4'd1);
            check($sformatf("hold%0d out_valid", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("hold%0d bcdreg", i),    bus.bcdreg,         32'hFFFFFFF8);
        end
        step(0, 0, 0, 1, 0, 0, 4'd0);
        check("hold clear out_valid", 32'(bus.out_valid), 32'h0);
        check("hold clear bcdreg",    bus.bcdreg,         32'hFFFFFFFF);

        // Asynchronous reset in the middle of fractional entry.
        step(1, 0, 0, 0, 0, 0, 4'd3);
        step(0, 1, 0, 0, 0, 0, 4'd0);
        step(1, 0, 0, 0, 0, 0, 4'd1);
        check("pre-reset bcdreg", bus.bcdreg, 32'hFFFFF3E1);
        #2;
        reset = 1'b1;
        #1;
        check("async bcdreg",    bus.bcdreg,         32'hFFFF_FFFF);
        check("async out_value", bus.out_value,      32'h0);
        check("async out_frac",  32'(bus.out_frac),  32'h0);
        check("async out_valid", 32'(bus.out_valid), 32'h0);
        check("async overflow",  32'(bus.overflow),  32'h0);
        check("async bad_digit", 32'(bus.bad_digit), 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ld  = ($urandom_range(0, 99) < 55);
            dpp = ($urandom_range(0, 99) < 10);
            bk  = ($urandom_range(0, 99) < 12);
            cl  = ($urandom_range(0, 99) < 3);
            cm  = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 40);
            dig = 4'($urandom_range(0, 11));
            step(ld, dpp, bk, cl, cm, rdy, dig);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
